// File: rtl/rcv_ctrl.sv
// Receive control unit for the serial receiver path.
// Synchronises the raw serial line and detects the start-bit falling edge.
// Enables the bit timer while a packet is clocked in, then sequences the
// stop-bit check. Finally it strobes the receive buffer, or raises a
// sticky framing error when the stop bit is bad.
// SYNC_STAGES must lie in 2..4.
module rcv_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic packet_done,
    input  logic stop_bit,
    output logic enable_timer,
    output logic sbc_clear,
    output logic sbc_enable,
    output logic load_buffer,
    output logic framing_error
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        RECEIVE   = 3'd2,
        STOP_CHK  = 3'd3,
        STOP_EVAL = 3'd4,
        LOAD      = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_out_s;
    logic                   start_detect_s;

    state_t state_q;
    state_t state_d;

    logic enable_timer_q, enable_timer_d;
    logic sbc_clear_q,    sbc_clear_d;
    logic sbc_enable_q,   sbc_enable_d;
    logic load_buffer_q,  load_buffer_d;
    logic framing_err_q,  framing_err_d;

    assign sync_out_s     = sync_q[SYNC_STAGES-1];
    assign start_detect_s = hist_q & ~sync_out_s;

    // Synchroniser chain and edge-history flop; both rest at the line-idle level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {SYNC_STAGES{1'b1}};
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
            hist_q <= sync_out_s;
        end
    end

    // Next-state logic. Start edges matter only in IDLE, and packet_done only in RECEIVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_detect_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START:   state_d = RECEIVE;
            RECEIVE: begin
                if (packet_done) begin
                    state_d = STOP_CHK;
                end else begin
                    state_d = RECEIVE;
                end
            end
            STOP_CHK: state_d = STOP_EVAL;
            STOP_EVAL: begin
                if (stop_bit) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The outputs are registered and decoded from the next state.
    // Each strobe therefore lines up with the cycle spent in its state.
    always_comb begin
        enable_timer_d = (state_d == RECEIVE);
        sbc_clear_d    = (state_d == START);
        sbc_enable_d   = (state_d == STOP_CHK);
        load_buffer_d  = (state_d == LOAD);
        if (state_d == START) begin
            framing_err_d = 1'b0;
        end else if ((state_q == STOP_EVAL) && !stop_bit) begin
            framing_err_d = 1'b1;
        end else begin
            framing_err_d = framing_err_q;
        end
    end

    // State and output registers. Reset aborts any packet in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            enable_timer_q <= 1'b0;
            sbc_clear_q    <= 1'b0;
            sbc_enable_q   <= 1'b0;
            load_buffer_q  <= 1'b0;
            framing_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            enable_timer_q <= enable_timer_d;
            sbc_clear_q    <= sbc_clear_d;
            sbc_enable_q   <= sbc_enable_d;
            load_buffer_q  <= load_buffer_d;
            framing_err_q  <= framing_err_d;
        end
    end

    assign enable_timer  = enable_timer_q;
    assign sbc_clear     = sbc_clear_q;
    assign sbc_enable    = sbc_enable_q;
    assign load_buffer   = load_buffer_q;
    assign framing_error = framing_err_q;

endmodule
